fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Read-side drain engine for the async FIFO. It sits in the rclk domain and drives the FIFO's rinc from rempty/rdata.
- It re-presents the words as a registered valid/ready stream toward downstream read-domain logic, with a 2-entry skid buffer for full throughput.
- It tags burst boundaries with m_last and supports a synchronous flush.

Parameters:
- DSIZE, 8, data width; must match the FIFO DSIZE.
- BURST_LEN, 16, beats per burst for m_last generation; legal range 1..65535.

Ports:
- rclk  input  1  read-domain clock.
- rrst  input  1  synchronous, active-high reset.
- rempty  input  1  FIFO empty flag (rclk domain).
- rdata  input  DSIZE  FIFO head word; valid whenever rempty=0 (show-ahead).
- rinc  output  1  FIFO read increment; pops the head at the rclk edge.
- flush  input  1  synchronous clear of the buffer and beat counter.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accept.
- m_data  output  DSIZE  output word.
- m_last  output  1  high on the final beat of each BURST_LEN burst.
- word_cnt  output  32  words delivered (RD_STATS_EN only, else 0).
- stall_cnt  output  32  backpressure cycles (RD_STATS_EN only, else 0).

Behaviour:
- Clocking and reset: single clock rclk. Reset is synchronous and active-high on rrst.
- Reset values:
  - m_valid=0, m_last=0, m_data=0, rinc=0.
  - Occupancy=0, beat counter=0, word_cnt=0, stall_cnt=0.
- Buffer: 2-entry register buffer (head/tail).
  - m_data, m_valid and m_last come straight from head registers; no combinational path from rdata.
- Pop request:
  - rinc = !rempty && occupancy<2 && !flush && !rrst.
  - rinc must not depend combinationally on m_ready.
- Capture: when rinc=1, rdata is written into the buffer at the same rclk edge.
  - It goes to head if the buffer is empty after this cycle's pop, otherwise to tail.
- Pop: accept = m_valid && m_ready. On accept, tail moves to head (if occupied).
- Occupancy states:
  - EMPTY(0): rinc -> ONE.
  - ONE(1):
    - rinc && !accept -> TWO.
    - accept && !rinc -> EMPTY.
    - both or neither -> ONE.
  - TWO(2):
    - accept -> ONE; rinc is 0 in TWO.
    - no accept -> hold.
- Latency: a word at the FIFO head with the buffer EMPTY at cycle N appears on m_data with m_valid=1 at N+1.
- Throughput: sustained 1 word/cycle when rempty=0 and m_ready=1; steady state is ONE.
- Ordering: strictly FIFO. No word is dropped or duplicated except on flush/reset.
- m_valid stability: once m_valid=1, m_data/m_last hold until accept.
- Beat counter:
  - Width 16. Increments on accept; wraps to 0 after BURST_LEN-1.
  - m_last = head beat index == BURST_LEN-1, computed at load time into head.
  - BURST_LEN=1 -> m_last=1 on every beat.
- Flush:
  - In the flush cycle rinc=0. At the edge, occupancy->0, m_valid->0 and beat counter->0.
  - Buffered words are discarded; the FIFO contents are untouched.
  - An accept coinciding with flush is ignored for stats.
- Reset mid-stream: same effect as flush, plus stats cleared. rinc=0 while rrst=1.
- rempty rising while the buffer holds data: the buffer keeps draining normally.

Optional Feature:
- Macro RD_STATS_EN.
- Defined:
  - word_cnt increments on each accept.
  - stall_cnt increments on each cycle with m_valid=1 && m_ready=0.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and are cleared by rrst only (not by flush).
- Undefined: the counters are not built; word_cnt and stall_cnt are tied to 0. The ports remain.

Test Plan:
- Reset, then a single word: rempty=0 with rdata=0xA5 at cycle N, m_ready=1 -> rinc=1 at N; m_valid=1, m_data=0xA5 at N+1; rinc then 0 once the FIFO is empty.
- Streaming: 32 words 0x00..0x1F, m_ready=1, BURST_LEN=16 -> one word per cycle after 1-cycle latency, in order; m_last=1 on 0x0F and 0x1F only.
- Backpressure: m_ready=0 for 5 cycles with the FIFO non-empty -> exactly 2 rinc pulses; m_data holds the first word. After m_ready=1, all words arrive in order with no gaps. With RD_STATS_EN, stall_cnt=5.
- Flush with 2 words buffered, 3 delivered so far -> next cycle m_valid=0 and rinc=0 during flush. The next word restarts the beat index at 0, so m_last comes 16 beats later.
- Mid-stream rrst for 1 cycle -> rinc=0 during reset; m_valid=0 after; word_cnt/stall_cnt=0. The stream resumes from the current FIFO head.
- BURST_LEN=1, 4 words -> m_last=1 on every beat.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pops the async FIFO into a 2-entry skid buffer and presents a
// registered valid/ready stream with burst-boundary tagging. Optional stats via RD_STATS_EN.
module fifo_rd_stream #(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned BURST_LEN = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last,
    output logic [31:0]      word_cnt,
    output logic [31:0]      stall_cnt
);

    localparam int unsigned BW = 16;
    localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e             state;
    occ_e             state_nxt;
    logic [DSIZE-1:0] head_data_nxt;
    logic [DSIZE-1:0] tail_data;
    logic [DSIZE-1:0] tail_data_nxt;
    logic [BW-1:0]    beat;
    logic [BW-1:0]    beat_nxt;
    logic             valid_nxt;
    logic             last_nxt;
    logic             accept;

    function automatic logic [BW-1:0] beat_wrap(input logic [BW-1:0] b);
        return (b == BEAT_MAX) ? '0 : BW'(b + 1'b1);
    endfunction

    assign accept = m_valid && m_ready;
    // Pop decision uses occupancy only, never m_ready.
    assign rinc   = !rempty && (state != TWO) && !flush && !rrst;

    always_comb begin
        state_nxt     = state;
        head_data_nxt = m_data;
        tail_data_nxt = tail_data;
        beat_nxt      = beat;
        valid_nxt     = 1'b0;
        last_nxt      = 1'b0;

        if (accept) begin
            beat_nxt = beat_wrap(beat);
        end

        case (state)
            EMPTY: begin
                if (rinc) begin
                    head_data_nxt = rdata;
                    state_nxt     = ONE;
                end
            end
            ONE: begin
                if (rinc && accept) begin
                    head_data_nxt = rdata;
                end else if (rinc) begin
                    tail_data_nxt = rdata;
                    state_nxt     = TWO;
                end else if (accept) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (accept) begin
                    head_data_nxt = tail_data;
                    state_nxt     = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase

        if (flush) begin
            state_nxt = EMPTY;
            beat_nxt  = '0;
        end

        // Head beat index equals the post-accept beat counter, so m_last is fixed at load.
        valid_nxt = (state_nxt != EMPTY);
        last_nxt  = valid_nxt && (beat_nxt == BEAT_MAX);
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state     <= EMPTY;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_data    <= '0;
            tail_data <= '0;
            beat      <= '0;
        end else begin
            state     <= state_nxt;
            m_valid   <= valid_nxt;
            m_last    <= last_nxt;
            m_data    <= head_data_nxt;
            tail_data <= tail_data_nxt;
            beat      <= beat_nxt;
        end
    end

`ifdef RD_STATS_EN
    // Saturating counters; flush does not clear them and a flushed accept is not counted.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept && !flush && (word_cnt != 32'hFFFF_FFFF)) begin
                word_cnt <= word_cnt + 32'd1;
            end
            if (m_valid && !m_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`else
    assign word_cnt  = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a queue models the show-ahead FIFO feeding two instances
// (BURST_LEN=16 and BURST_LEN=1). Stats expectations follow RD_STATS_EN.
module tb_fifo_rd_stream;

    localparam int unsigned DSIZE = 8;
`ifdef RD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rrst;
    logic             rempty, rinc, flush, m_valid, m_ready, m_last;
    logic [DSIZE-1:0] rdata, m_data;
    logic [31:0]      word_cnt, stall_cnt;
    logic             rempty1, rinc1, flush1, m_valid1, m_ready1, m_last1;
    logic [DSIZE-1:0] rdata1, m_data1;
    logic [31:0]      word_cnt1, stall_cnt1;

    logic [DSIZE-1:0] q[$];
    logic [DSIZE-1:0] q1[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DSIZE(DSIZE), .BURST_LEN(16)) u_dut (
        .rclk(clk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .word_cnt(word_cnt), .stall_cnt(stall_cnt)
    );

    fifo_rd_stream #(.DSIZE(DSIZE), .BURST_LEN(1)) u_dut1 (
        .rclk(clk), .rrst(rrst), .rempty(rempty1), .rdata(rdata1), .rinc(rinc1),
        .flush(flush1), .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
        .m_last(m_last1), .word_cnt(word_cnt1), .stall_cnt(stall_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        rempty  = (q.size() == 0);
        rdata   = (q.size() != 0) ? q[0] : 8'h00;
        rempty1 = (q1.size() == 0);
        rdata1  = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    // One clock: the FIFO model pops on rinc seen before the edge; returns settled after negedge.
    task automatic step();
        logic p, p1;
        p  = rinc;
        p1 = rinc1;
        @(posedge clk);
        #1;
        if (p && q.size() != 0) void'(q.pop_front());
        if (p1 && q1.size() != 0) void'(q1.pop_front());
        refresh();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rrst    = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        #1;
        step();
        rrst = 1'b0;
        #1;
    endtask

    initial begin
        int exp;
        int pulses;
        bit started;
        logic [DSIZE-1:0] nxt;

        rrst = 1'b1; flush = 1'b0; m_ready = 1'b0; flush1 = 1'b0; m_ready1 = 1'b0;
        refresh();
        @(negedge clk);
        #1;
        step();

        // Reset, then a single word
        q.push_back(8'hA5);
        refresh();
        #1;
        chk("rinc_in_rst", 32'(rinc), 32'd0);
        step();
        rrst = 1'b0;
        #1;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_words", word_cnt, 32'd0);
        chk("rst_stalls", stall_cnt, 32'd0);
        chk("single_rinc_n", 32'(rinc), 32'd1);
        m_ready = 1'b1;
        step();
        chk("single_valid", 32'(m_valid), 32'd1);
        chk("single_data", 32'(m_data), 32'hA5);
        chk("single_last", 32'(m_last), 32'd0);
        chk("single_rinc_after", 32'(rinc), 32'd0);
        step();
        chk("single_drained", 32'(m_valid), 32'd0);

        // Streaming 32 words, BURST_LEN=16
        do_reset();
        for (int i = 0; i < 32; i++) q.push_back(DSIZE'(i));
        refresh();
        m_ready = 1'b1;
        #1;
        exp = 0;
        started = 1'b0;
        for (int c = 0; c < 40 && exp < 32; c++) begin
            if (m_valid) begin
                chk("stream_data", 32'(m_data), 32'(exp));
                chk("stream_last", 32'(m_last), (exp == 15 || exp == 31) ? 32'd1 : 32'd0);
                exp++;
                started = 1'b1;
            end else if (started) begin
                chk("stream_gap", 32'(m_valid), 32'd1);
            end
            step();
        end
        chk("stream_count", 32'(exp), 32'd32);

        // Backpressure
        do_reset();
        for (int i = 0; i < 8; i++) q.push_back(DSIZE'(8'h40 + i));
        refresh();
        #1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            pulses += int'(rinc);
            step();
        end
        chk("bp_rinc_pulses", 32'(pulses), 32'd2);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_hold", 32'(m_data), 32'h40);
        chk("bp_stalls", stall_cnt, STATS ? 32'd5 : 32'd0);
        m_ready = 1'b1;
        #1;
        exp = 8'h40;
        for (int c = 0; c < 12 && exp < 8'h48; c++) begin
            chk("bp_nogap", 32'(m_valid), 32'd1);
            if (m_valid) begin
                chk("bp_data", 32'(m_data), 32'(exp));
                exp++;
            end
            step();
        end
        chk("bp_count", 32'(exp), 32'h48);
        chk("bp_words", word_cnt, STATS ? 32'd8 : 32'd0);

        // Flush with two words buffered after three delivered
        do_reset();
        for (int i = 0; i < 32; i++) q.push_back(DSIZE'(8'h60 + i));
        refresh();
        m_ready = 1'b1;
        #1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("fl_pre_data", 32'(m_data), 32'(8'h60 + i));
            step();
        end
        m_ready = 1'b0;
        #1;
        step();
        flush = 1'b1;
        #1;
        chk("fl_two_valid", 32'(m_valid), 32'd1);
        chk("fl_rinc", 32'(rinc), 32'd0);
        step();
        flush = 1'b0;
        m_ready = 1'b1;
        #1;
        chk("fl_valid_off", 32'(m_valid), 32'd0);
        chk("fl_rinc_resume", 32'(rinc), 32'd1);
        step();
        exp = 8'h65;
        for (int i = 0; i < 20; i++) begin
            chk("fl_valid", 32'(m_valid), 32'd1);
            chk("fl_data", 32'(m_data), 32'(exp));
            chk("fl_last", 32'(m_last), (exp == 8'h74) ? 32'd1 : 32'd0);
            exp++;
            step();
        end
        // Flush in the single-entry state while an accept happens
        flush = 1'b1;
        #1;
        chk("fl1_rinc", 32'(rinc), 32'd0);
        step();
        flush = 1'b0;
        #1;
        chk("fl1_valid_off", 32'(m_valid), 32'd0);
        chk("fl1_words", word_cnt, STATS ? 32'd23 : 32'd0);
        chk("fl1_stalls", stall_cnt, STATS ? 32'd2 : 32'd0);
        step();
        chk("fl1_data", 32'(m_data), 32'h7A);
        chk("fl1_last", 32'(m_last), 32'd0);

        // Mid-stream reset
        rrst = 1'b1;
        #1;
        chk("mrst_rinc", 32'(rinc), 32'd0);
        nxt = q[0];
        step();
        rrst = 1'b0;
        #1;
        chk("mrst_valid", 32'(m_valid), 32'd0);
        chk("mrst_words", word_cnt, 32'd0);
        chk("mrst_stalls", stall_cnt, 32'd0);
        step();
        chk("mrst_resume_valid", 32'(m_valid), 32'd1);
        chk("mrst_resume_data", 32'(m_data), 32'(nxt));

        // BURST_LEN=1 instance
        for (int i = 0; i < 4; i++) q1.push_back(DSIZE'(8'h90 + i));
        refresh();
        m_ready1 = 1'b1;
        #1;
        exp = 8'h90;
        for (int c = 0; c < 8; c++) begin
            if (m_valid1) begin
                chk("b1_data", 32'(m_data1), 32'(exp));
                chk("b1_last", 32'(m_last1), 32'd1);
                exp++;
            end
            step();
        end
        chk("b1_count", 32'(exp), 32'h94);
        chk("b1_words", word_cnt1, STATS ? 32'd4 : 32'd0);
        chk("b1_stalls", stall_cnt1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
